// File: rtl/dual_port_ram_arb_if.sv
// Port bundle for dual_port_ram_arb: request/response signals of ports A and B.
interface dual_port_ram_arb_if #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned BYTE_WIDTH = 8,
   parameter int unsigned ADDR_WIDTH = 4
);
   localparam int unsigned NUM_BYTES = DATA_WIDTH / BYTE_WIDTH;

   logic                  en_a;
   logic                  we_a;
   logic [NUM_BYTES-1:0]  be_a;
   logic [ADDR_WIDTH-1:0] addr_a;
   logic [DATA_WIDTH-1:0] din_a;
   logic [DATA_WIDTH-1:0] dout_a;
   logic                  dvalid_a;

   logic                  en_b;
   logic                  we_b;
   logic [NUM_BYTES-1:0]  be_b;
   logic [ADDR_WIDTH-1:0] addr_b;
   logic [DATA_WIDTH-1:0] din_b;
   logic [DATA_WIDTH-1:0] dout_b;
   logic                  dvalid_b;

   modport master (
      output en_a, we_a, be_a, addr_a, din_a,
      output en_b, we_b, be_b, addr_b, din_b,
      input  dout_a, dvalid_a, dout_b, dvalid_b
   );

   modport slave (
      input  en_a, we_a, be_a, addr_a, din_a,
      input  en_b, we_b, be_b, addr_b, din_b,
      output dout_a, dvalid_a, dout_b, dvalid_b
   );
endinterface

// File: rtl/dual_port_ram_arb.sv
// dual_port_ram_arb: single-clock true dual-port RAM with byte enables,
// read-first/write-first selection, optional output register, and fixed or
// round-robin arbitration of same-address write collisions. A zero-fill
// sweep runs after every reset. Optional collision counter is built when
// DPRAM_COLL_STATS_EN is defined.
module dual_port_ram_arb #(
   parameter int unsigned DATA_WIDTH    = 32,
   parameter int unsigned BYTE_WIDTH    = 8,
   parameter int unsigned ADDR_WIDTH    = 4,
   parameter bit          PRIORITY_MODE = 1'b0,
   parameter bit          RD_MODE       = 1'b0,
   parameter bit          OUT_REG       = 1'b0
) (
   input  logic                clk,
   input  logic                rst_n,
   dual_port_ram_arb_if.slave  bus,
   output logic                init_done,
   output logic                collision
`ifdef DPRAM_COLL_STATS_EN
   ,
   input  logic                clr_stats,
   output logic [15:0]         coll_cnt
`endif
);
   localparam int unsigned DEPTH     = 2 ** ADDR_WIDTH;
   localparam int unsigned NUM_BYTES = DATA_WIDTH / BYTE_WIDTH;

   if ((DATA_WIDTH % BYTE_WIDTH) != 0) begin : g_bad_width
      $error("DATA_WIDTH must be a multiple of BYTE_WIDTH");
   end

   typedef enum logic {ST_INIT, ST_READY} state_t;

   state_t                state;
   logic [ADDR_WIDTH-1:0] init_ptr;
   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic                  ready;
   logic                  acc_a, acc_b, wr_a, wr_b;
   logic                  same_addr, coll_c, a_wins, keep_a, keep_b;
   logic                  prio_b;
   logic [DATA_WIDTH-1:0] old_a, old_b, post_a, post_b, rd_a, rd_b;
   logic                  v1_a, v1_b;
   logic [DATA_WIDTH-1:0] d1_a, d1_b;

   // Overlay the enabled bytes of new_w onto old_w.
   function automatic logic [DATA_WIDTH-1:0] merge_bytes(
      input logic [DATA_WIDTH-1:0] old_w,
      input logic [DATA_WIDTH-1:0] new_w,
      input logic [NUM_BYTES-1:0]  be
   );
      logic [DATA_WIDTH-1:0] res;
      res = old_w;
      for (int unsigned i = 0; i < NUM_BYTES; i++) begin
         if (be[i]) res[i*BYTE_WIDTH +: BYTE_WIDTH] = new_w[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
      return res;
   endfunction

   // Init/ready control: zero-fill sweep of one address per cycle after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_INIT;
         init_ptr  <= '0;
         init_done <= 1'b0;
      end else begin
         case (state)
            ST_INIT: begin
               init_ptr <= init_ptr + ADDR_WIDTH'(1);
               if (init_ptr == ADDR_WIDTH'(DEPTH - 1)) begin
                  state     <= ST_READY;
                  init_done <= 1'b1;
               end
            end
            ST_READY: state <= ST_READY;
            default: begin
               state     <= ST_INIT;
               init_ptr  <= '0;
               init_done <= 1'b0;
            end
         endcase
      end
   end

   // Access decode, collision arbitration and post-write word per port.
   always_comb begin
      ready     = (state == ST_READY);
      acc_a     = ready & bus.en_a;
      acc_b     = ready & bus.en_b;
      wr_a      = acc_a & bus.we_a;
      wr_b      = acc_b & bus.we_b;
      same_addr = (bus.addr_a == bus.addr_b);
      coll_c    = wr_a & wr_b & same_addr;
      a_wins    = PRIORITY_MODE ? ~prio_b : 1'b1;
      keep_a    = wr_a & ~(coll_c & ~a_wins);
      keep_b    = wr_b & ~(coll_c & a_wins);
      old_a     = mem[bus.addr_a];
      old_b     = mem[bus.addr_b];
      post_a    = old_a;
      post_b    = old_b;
      // Only one write survives per address, so at most one merge applies to each word.
      if (keep_a)             post_a = merge_bytes(post_a, bus.din_a, bus.be_a);
      if (keep_b && same_addr) post_a = merge_bytes(post_a, bus.din_b, bus.be_b);
      if (keep_b)             post_b = merge_bytes(post_b, bus.din_b, bus.be_b);
      if (keep_a && same_addr) post_b = merge_bytes(post_b, bus.din_a, bus.be_a);
      rd_a      = RD_MODE ? post_a : old_a;
      rd_b      = RD_MODE ? post_b : old_b;
   end

   // Storage array: sweep writes while initialising, surviving port writes after.
   always_ff @(posedge clk) begin
      if (!ready) begin
         mem[init_ptr] <= '0;
      end else begin
         if (keep_a) mem[bus.addr_a] <= post_a;
         if (keep_b) mem[bus.addr_b] <= post_b;
      end
   end

   // First read stage, collision pulse and round-robin pointer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1_a      <= 1'b0;
         v1_b      <= 1'b0;
         d1_a      <= '0;
         d1_b      <= '0;
         collision <= 1'b0;
         prio_b    <= 1'b0;
      end else begin
         v1_a      <= acc_a;
         v1_b      <= acc_b;
         if (acc_a) d1_a <= rd_a;
         if (acc_b) d1_b <= rd_b;
         collision <= coll_c;
         if (PRIORITY_MODE && coll_c) prio_b <= ~prio_b;
      end
   end

   if (OUT_REG) begin : g_out_reg
      logic                  v2_a, v2_b;
      logic [DATA_WIDTH-1:0] d2_a, d2_b;

      // Second read stage; data only advances with a valid beat so dout holds.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            v2_a <= 1'b0;
            v2_b <= 1'b0;
            d2_a <= '0;
            d2_b <= '0;
         end else begin
            v2_a <= v1_a;
            v2_b <= v1_b;
            if (v1_a) d2_a <= d1_a;
            if (v1_b) d2_b <= d1_b;
         end
      end

      assign bus.dout_a   = d2_a;
      assign bus.dout_b   = d2_b;
      assign bus.dvalid_a = v2_a;
      assign bus.dvalid_b = v2_b;
   end else begin : g_no_out_reg
      assign bus.dout_a   = d1_a;
      assign bus.dout_b   = d1_b;
      assign bus.dvalid_a = v1_a;
      assign bus.dvalid_b = v1_b;
   end

`ifdef DPRAM_COLL_STATS_EN
   // Saturating collision counter; clear takes precedence over increment.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         coll_cnt <= 16'h0;
      end else if (clr_stats) begin
         coll_cnt <= 16'h0;
      end else if (coll_c && (coll_cnt != 16'hFFFF)) begin
         coll_cnt <= coll_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_dual_port_ram_arb.sv
// Bench for dual_port_ram_arb: two instances share stimulus.
// dut0: A-priority, read-first, latency 1. dut1: round-robin, write-first, latency 2.
module tb_dual_port_ram_arb;
   typedef struct packed {
      logic        en;
      logic        we;
      logic [3:0]  be;
      logic [3:0]  addr;
      logic [31:0] din;
   } preq_t;

   typedef struct packed {
      preq_t       a;
      preq_t       b;
      logic        coll;
      logic [31:0] e0a;
      logic [31:0] e0b;
      logic [31:0] e1a;
      logic [31:0] e1b;
   } vec_t;

   localparam int NV = 15;
   localparam preq_t NOP = '0;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic init_done0, init_done1, coll0, coll1;
   preq_t cur_a = '0, cur_b = '0;
   vec_t prev_v = '0;
   vec_t vec [NV];
   logic [31:0] last0a = '0, last0b = '0, last1a = '0, last1b = '0;
   int n_cmp = 0;
   int n_bad = 0;
`ifdef DPRAM_COLL_STATS_EN
   logic        clr_stats = 1'b0;
   logic [15:0] coll_cnt0, coll_cnt1;
`endif

   dual_port_ram_arb_if #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .ADDR_WIDTH(4)) bus0 ();
   dual_port_ram_arb_if #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .ADDR_WIDTH(4)) bus1 ();

   assign bus0.en_a = cur_a.en;   assign bus1.en_a = cur_a.en;
   assign bus0.we_a = cur_a.we;   assign bus1.we_a = cur_a.we;
   assign bus0.be_a = cur_a.be;   assign bus1.be_a = cur_a.be;
   assign bus0.addr_a = cur_a.addr; assign bus1.addr_a = cur_a.addr;
   assign bus0.din_a = cur_a.din; assign bus1.din_a = cur_a.din;
   assign bus0.en_b = cur_b.en;   assign bus1.en_b = cur_b.en;
   assign bus0.we_b = cur_b.we;   assign bus1.we_b = cur_b.we;
   assign bus0.be_b = cur_b.be;   assign bus1.be_b = cur_b.be;
   assign bus0.addr_b = cur_b.addr; assign bus1.addr_b = cur_b.addr;
   assign bus0.din_b = cur_b.din; assign bus1.din_b = cur_b.din;

   dual_port_ram_arb #(
      .DATA_WIDTH(32), .BYTE_WIDTH(8), .ADDR_WIDTH(4),
      .PRIORITY_MODE(1'b0), .RD_MODE(1'b0), .OUT_REG(1'b0)
   ) dut0 (
      .clk(clk), .rst_n(rst_n), .bus(bus0), .init_done(init_done0), .collision(coll0)
`ifdef DPRAM_COLL_STATS_EN
      , .clr_stats(clr_stats), .coll_cnt(coll_cnt0)
`endif
   );

   dual_port_ram_arb #(
      .DATA_WIDTH(32), .BYTE_WIDTH(8), .ADDR_WIDTH(4),
      .PRIORITY_MODE(1'b1), .RD_MODE(1'b1), .OUT_REG(1'b1)
   ) dut1 (
      .clk(clk), .rst_n(rst_n), .bus(bus1), .init_done(init_done1), .collision(coll1)
`ifdef DPRAM_COLL_STATS_EN
      , .clr_stats(clr_stats), .coll_cnt(coll_cnt1)
`endif
   );

   always #5 clk = ~clk;

   function automatic preq_t rd(input logic [3:0] a);
      return '{1'b1, 1'b0, 4'h0, a, 32'h0};
   endfunction

   function automatic preq_t wr(input logic [3:0] be, input logic [3:0] a, input logic [31:0] d);
      return '{1'b1, 1'b1, be, a, d};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk_port(input string name, input logic dv, input logic [31:0] d,
                           input logic ev, input logic [31:0] ed, inout logic [31:0] last);
      chk({name, ".dvalid"}, 32'(dv), 32'(ev));
      if (ev) last = ed;
      chk({name, ".dout"}, d, last);
   endtask

   // Apply one request vector, wait one cycle, check dut0 (this vector) and dut1 (previous one).
   task automatic step(input vec_t v);
      cur_a = v.a;
      cur_b = v.b;
      @(negedge clk);
      chk("collision0", 32'(coll0), 32'(v.coll));
      chk("collision1", 32'(coll1), 32'(v.coll));
      chk_port("d0_a", bus0.dvalid_a, bus0.dout_a, v.a.en, v.e0a, last0a);
      chk_port("d0_b", bus0.dvalid_b, bus0.dout_b, v.b.en, v.e0b, last0b);
      chk_port("d1_a", bus1.dvalid_a, bus1.dout_a, prev_v.a.en, prev_v.e1a, last1a);
      chk_port("d1_b", bus1.dvalid_b, bus1.dout_b, prev_v.b.en, prev_v.e1b, last1b);
      prev_v = v;
   endtask

   task automatic chk_reset();
      chk("rst.init_done0", 32'(init_done0), 32'h0);
      chk("rst.init_done1", 32'(init_done1), 32'h0);
      chk("rst.collision0", 32'(coll0), 32'h0);
      chk("rst.collision1", 32'(coll1), 32'h0);
      chk("rst.dvalid0_a", 32'(bus0.dvalid_a), 32'h0);
      chk("rst.dvalid0_b", 32'(bus0.dvalid_b), 32'h0);
      chk("rst.dvalid1_a", 32'(bus1.dvalid_a), 32'h0);
      chk("rst.dvalid1_b", 32'(bus1.dvalid_b), 32'h0);
      chk("rst.dout0_a", bus0.dout_a, 32'h0);
      chk("rst.dout0_b", bus0.dout_b, 32'h0);
      chk("rst.dout1_a", bus1.dout_a, 32'h0);
      chk("rst.dout1_b", bus1.dout_b, 32'h0);
`ifdef DPRAM_COLL_STATS_EN
      chk("rst.coll_cnt0", 32'(coll_cnt0), 32'h0);
      chk("rst.coll_cnt1", 32'(coll_cnt1), 32'h0);
`endif
   endtask

   // Release reset while hammering addr 5 with writes; the sweep must take 16 cycles and ignore them.
   task automatic init_seq();
      cur_a = wr(4'hF, 4'd5, 32'hDEADBEEF);
      cur_b = wr(4'hF, 4'd5, 32'hFEEDF00D);
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 1; c <= 16; c++) begin
         @(negedge clk);
         chk($sformatf("init_done0@%0d", c), 32'(init_done0), 32'(c == 16));
         chk($sformatf("init_done1@%0d", c), 32'(init_done1), 32'(c == 16));
         chk("init.dvalid0", 32'({bus0.dvalid_a, bus0.dvalid_b}), 32'h0);
         chk("init.dvalid1", 32'({bus1.dvalid_a, bus1.dvalid_b}), 32'h0);
         chk("init.collision", 32'({coll0, coll1}), 32'h0);
      end
      cur_a = NOP;
      cur_b = NOP;
      prev_v = '0;
      last0a = '0; last0b = '0; last1a = '0; last1b = '0;
   endtask

   initial begin
      // dut0 expectations: e0a/e0b; dut1 expectations: e1a/e1b.
      vec[0]  = '{rd(4'd3), rd(4'd9), 1'b0, 32'h0, 32'h0, 32'h0, 32'h0};
      vec[1]  = '{wr(4'hF, 4'd5, 32'h11223344), NOP, 1'b0, 32'h0, 32'h0, 32'h11223344, 32'h0};
      vec[2]  = '{rd(4'd5), wr(4'b0101, 4'd5, 32'hAABBCCDD), 1'b0,
                  32'h11223344, 32'h11223344, 32'h11BB33DD, 32'h11BB33DD};
      vec[3]  = '{rd(4'd5), rd(4'd5), 1'b0, 32'h11BB33DD, 32'h11BB33DD, 32'h11BB33DD, 32'h11BB33DD};
      vec[4]  = '{wr(4'hF, 4'd2, 32'hCAFE0001), rd(4'd2), 1'b0, 32'h0, 32'h0, 32'hCAFE0001, 32'hCAFE0001};
      vec[5]  = '{wr(4'hF, 4'd7, 32'h1), wr(4'hF, 4'd7, 32'h2), 1'b1, 32'h0, 32'h0, 32'h1, 32'h1};
      vec[6]  = '{wr(4'hF, 4'd7, 32'h1), wr(4'hF, 4'd7, 32'h2), 1'b1, 32'h1, 32'h1, 32'h2, 32'h2};
      vec[7]  = '{wr(4'hF, 4'd7, 32'h1), wr(4'hF, 4'd7, 32'h2), 1'b1, 32'h1, 32'h1, 32'h1, 32'h1};
      vec[8]  = '{rd(4'd7), rd(4'd2), 1'b0, 32'h1, 32'hCAFE0001, 32'h1, 32'hCAFE0001};
      vec[9]  = '{wr(4'b0011, 4'd8, 32'h0000FFFF), wr(4'b1000, 4'd9, 32'h12345678), 1'b0,
                  32'h0, 32'h0, 32'h0000FFFF, 32'h12000000};
      vec[10] = '{wr(4'b0001, 4'd8, 32'hAAAAAAAA), wr(4'b1110, 4'd8, 32'hBBBBBBBB), 1'b1,
                  32'h0000FFFF, 32'h0000FFFF, 32'hBBBBBBFF, 32'hBBBBBBFF};
      vec[11] = '{rd(4'd8), rd(4'd9), 1'b0, 32'h0000FFAA, 32'h12000000, 32'hBBBBBBFF, 32'h12000000};
      vec[12] = '{'{1'b0, 1'b1, 4'hF, 4'd8, 32'h55555555}, '{1'b0, 1'b1, 4'hF, 4'd9, 32'h66666666},
                  1'b0, 32'h0, 32'h0, 32'h0, 32'h0};
      vec[13] = '{rd(4'd8), NOP, 1'b0, 32'h0000FFAA, 32'h0, 32'hBBBBBBFF, 32'h0};
      vec[14] = '{wr(4'h0, 4'd9, 32'hFFFFFFFF), rd(4'd9), 1'b0,
                  32'h12000000, 32'h12000000, 32'h12000000, 32'h12000000};

      // Reset values, then the init sweep.
      #12;
      chk_reset();
      init_seq();

      // Every address reads back zero after the sweep.
      for (int i = 0; i < 16; i++) begin
         step('{rd(4'(i)), rd(4'(15 - i)), 1'b0, 32'h0, 32'h0, 32'h0, 32'h0});
      end

      // Directed table.
      for (int k = 0; k < NV; k++) step(vec[k]);
      step('0);
      step('0);

`ifdef DPRAM_COLL_STATS_EN
      chk("coll_cnt0", 32'(coll_cnt0), 32'd4);
      chk("coll_cnt1", 32'(coll_cnt1), 32'd4);
      clr_stats = 1'b1;
      step('{wr(4'hF, 4'd10, 32'h5), wr(4'hF, 4'd10, 32'h6), 1'b1, 32'h0, 32'h0, 32'h5, 32'h5});
      clr_stats = 1'b0;
      chk("coll_cnt0.clr", 32'(coll_cnt0), 32'd0);
      chk("coll_cnt1.clr", 32'(coll_cnt1), 32'd0);
      step('{wr(4'hF, 4'd10, 32'h5), wr(4'hF, 4'd10, 32'h6), 1'b1, 32'h5, 32'h5, 32'h6, 32'h6});
      chk("coll_cnt0.inc", 32'(coll_cnt0), 32'd1);
      chk("coll_cnt1.inc", 32'(coll_cnt1), 32'd1);
      step('0);
      step('0);
`endif

      // Read burst interrupted by reset between edges.
      for (int i = 0; i < 3; i++) begin
         step('{rd(4'd5), rd(4'd2), 1'b0, 32'h11BB33DD, 32'hCAFE0001, 32'h11BB33DD, 32'hCAFE0001});
      end
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk_reset();
      init_seq();
      step('{rd(4'd5), rd(4'd5), 1'b0, 32'h0, 32'h0, 32'h0, 32'h0});
      step('0);
      step('0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
